// File: rtl/victim_buffer.sv
// victim_buffer: fully associative victim buffer beside a write-back L1 dcache.
// Optional VICTIM_STATS_EN adds saturating hit/miss/write-back counters.
module victim_buffer #(
    parameter int TAG_WIDTH   = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [TAG_WIDTH-1:0]  ins_tag,
    input  logic [DATA_WIDTH-1:0] ins_data,
    input  logic                  ins_dirty,
    input  logic                  lkp_valid,
    input  logic [TAG_WIDTH-1:0]  lkp_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_dirty,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    output logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush_req,
    output logic                  flush_done
`ifdef VICTIM_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_wbs
`endif
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FLUSH_SCAN = 2'd1,
        ST_FLUSH_WB   = 2'd2,
        ST_FLUSH_DONE = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_ENTRIES-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   tag_d  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       scan_q, scan_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [TAG_WIDTH-1:0]   wb_tag_q, wb_tag_d;
    logic [DATA_WIDTH-1:0]  wb_data_q, wb_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_dirty_q, rsp_dirty_d;
    logic                   flush_done_q, flush_done_d;

    logic [NUM_ENTRIES-1:0] lkp_match_s, ins_match_s;
    logic                   lkp_hit_s, ins_same_s, ins_free_s;
    logic [IDX_W-1:0]       lkp_idx_s, ins_slot_s;
    logic                   ins_ready_s, ins_fire_s, wb_fire_s;

    // Tag compare and slot selection, all against the pre-cycle contents.
    always_comb begin
        lkp_match_s = {NUM_ENTRIES{1'b0}};
        ins_match_s = {NUM_ENTRIES{1'b0}};
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lkp_match_s[i] = valid_q[i] && (tag_q[i] == lkp_tag);
            ins_match_s[i] = valid_q[i] && (tag_q[i] == ins_tag);
        end
        lkp_hit_s  = lkp_valid && (state_q == ST_IDLE) && (|lkp_match_s);
        lkp_idx_s  = first_set(lkp_match_s);
        ins_same_s = |ins_match_s;
        ins_free_s = ~(&valid_q);
        if (ins_same_s) begin
            ins_slot_s = first_set(ins_match_s);
        end else if (ins_free_s) begin
            ins_slot_s = first_set(~valid_q);
        end else begin
            ins_slot_s = ptr_q;
        end
    end

    // The write-back register may drain and refill on the same edge.
    assign ins_ready_s = (state_q == ST_IDLE) && !(wb_valid_q && !wb_ready);
    assign ins_fire_s  = ins_valid && ins_ready_s;
    assign wb_fire_s   = wb_valid_q && wb_ready;

    // Next-state for entries, write-back register, response and flush FSM.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        ptr_d        = ptr_q;
        scan_d       = scan_q;
        wb_valid_d   = wb_valid_q;
        wb_tag_d     = wb_tag_q;
        wb_data_d    = wb_data_q;
        rsp_valid_d  = lkp_valid;
        rsp_hit_d    = lkp_hit_s;
        rsp_data_d   = rsp_data_q;
        rsp_dirty_d  = rsp_dirty_q;
        flush_done_d = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            tag_d[i]  = tag_q[i];
            data_d[i] = data_q[i];
        end

        if (lkp_hit_s) begin
            rsp_data_d         = data_q[lkp_idx_s];
            rsp_dirty_d        = dirty_q[lkp_idx_s];
            valid_d[lkp_idx_s] = 1'b0;
        end else begin
            valid_d = valid_d;
        end

        if (wb_fire_s) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (ins_fire_s) begin
                    tag_d[ins_slot_s]   = ins_tag;
                    data_d[ins_slot_s]  = ins_data;
                    dirty_d[ins_slot_s] = ins_dirty;
                    valid_d[ins_slot_s] = 1'b1;
                    if (!ins_same_s && !ins_free_s) begin
                        ptr_d = ptr_q + IDX_ONE;
                        // A victim just handed back through rsp needs no write-back.
                        if (dirty_q[ins_slot_s] && !(lkp_hit_s && (lkp_idx_s == ins_slot_s))) begin
                            wb_valid_d = 1'b1;
                            wb_tag_d   = tag_q[ins_slot_s];
                            wb_data_d  = data_q[ins_slot_s];
                        end else begin
                            wb_valid_d = wb_valid_d;
                        end
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
                if (flush_req) begin
                    state_d = ST_FLUSH_SCAN;
                    scan_d  = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                if (wb_valid_q) begin
                    state_d = ST_FLUSH_SCAN;
                end else if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    wb_valid_d = 1'b1;
                    wb_tag_d   = tag_q[scan_q];
                    wb_data_d  = data_q[scan_q];
                    state_d    = ST_FLUSH_WB;
                end else if (scan_q == LAST_IDX) begin
                    state_d = ST_FLUSH_DONE;
                end else begin
                    scan_d = scan_q + IDX_ONE;
                end
            end
            ST_FLUSH_WB: begin
                if (wb_fire_s) begin
                    dirty_d[scan_q] = 1'b0;
                    if (scan_q == LAST_IDX) begin
                        state_d = ST_FLUSH_DONE;
                    end else begin
                        scan_d  = scan_q + IDX_ONE;
                        state_d = ST_FLUSH_SCAN;
                    end
                end else begin
                    state_d = ST_FLUSH_WB;
                end
            end
            ST_FLUSH_DONE: begin
                valid_d      = {NUM_ENTRIES{1'b0}};
                ptr_d        = {IDX_W{1'b0}};
                flush_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= {NUM_ENTRIES{1'b0}};
            dirty_q      <= {NUM_ENTRIES{1'b0}};
            ptr_q        <= {IDX_W{1'b0}};
            scan_q       <= {IDX_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= {TAG_WIDTH{1'b0}};
            wb_data_q    <= {DATA_WIDTH{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_data_q   <= {DATA_WIDTH{1'b0}};
            rsp_dirty_q  <= 1'b0;
            flush_done_q <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= {TAG_WIDTH{1'b0}};
                data_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            ptr_q        <= ptr_d;
            scan_q       <= scan_d;
            wb_valid_q   <= wb_valid_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_data_q   <= rsp_data_d;
            rsp_dirty_q  <= rsp_dirty_d;
            flush_done_q <= flush_done_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign ins_ready  = ins_ready_s && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_dirty  = rsp_dirty_q;
    assign wb_valid   = wb_valid_q;
    assign wb_tag     = wb_tag_q;
    assign wb_data    = wb_data_q;
    assign flush_done = flush_done_q;

`ifdef VICTIM_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;
    logic [31:0] stat_wbs_q, stat_wbs_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        if (en && (val != 32'hFFFF_FFFF)) begin
            return val + 32'd1;
        end else begin
            return val;
        end
    endfunction

    // Saturating event counters; lookups during a flush count as misses.
    always_comb begin
        stat_hits_d   = sat_inc(stat_hits_q, lkp_hit_s);
        stat_misses_d = sat_inc(stat_misses_q, lkp_valid && !lkp_hit_s);
        stat_wbs_d    = sat_inc(stat_wbs_q, wb_fire_s);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q   <= 32'd0;
            stat_misses_q <= 32'd0;
            stat_wbs_q    <= 32'd0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_wbs_q    <= stat_wbs_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_wbs    = stat_wbs_q;
`endif

endmodule

// File: tb/tb_victim_buffer.sv
// Scoreboard bench for victim_buffer: directed scenarios plus randomized traffic
// checked against an entry-array reference model.
module tb_victim_buffer;
    localparam int TW = 32;
    localparam int DW = 128;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ins_valid, ins_ready, ins_dirty;
    logic [TW-1:0] ins_tag, lkp_tag, wb_tag;
    logic [DW-1:0] ins_data, rsp_data, wb_data;
    logic          lkp_valid, rsp_valid, rsp_hit, rsp_dirty;
    logic          wb_valid, wb_ready, flush_req, flush_done;

    victim_buffer #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag),
        .ins_data(ins_data), .ins_dirty(ins_dirty),
        .lkp_valid(lkp_valid), .lkp_tag(lkp_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_dirty(rsp_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; bit hit; logic [DW-1:0] data; bit dirty; } rsp_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } wb_t;

    rsp_t rsp_q[$];
    wb_t  wb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: the buffer as a table of entries plus a replacement pointer.
    bit            m_valid [NE];
    logic [TW-1:0] m_tag   [NE];
    logic [DW-1:0] m_data  [NE];
    bit            m_dirty [NE];
    int            m_ptr;
    bit            m_pend;
    logic [DW-1:0] m_last_data;
    bit            m_last_dirty;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input logic [TW-1:0] t);
        return {t, ~t, t ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | t};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0; m_pend = 1'b0; m_last_data = '0; m_last_dirty = 1'b0;
        rsp_q.delete(); wb_q.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected responses/write-backs whenever the DUT presents them.
    rsp_t          e;
    wb_t           w;
    bit            wb_stall = 1'b0;
    logic [TW-1:0] stall_tag;
    logic [DW-1:0] stall_data;
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                e = rsp_q.pop_front();
                chk("rsp_valid", rsp_valid, 1'b1);
                chk("rsp_hit", rsp_hit, e.hit);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_dirty", rsp_dirty, e.dirty);
            end else if (rsp_valid) begin
                chk("rsp_spurious", rsp_valid, 1'b0);
            end
            if (wb_stall) begin
                chk("wb_hold_valid", wb_valid, 1'b1);
                chk("wb_hold_tag", wb_tag, stall_tag);
                chk("wb_hold_data", wb_data, stall_data);
            end
            if (wb_valid && wb_ready) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", wb_tag, {DW{1'b1}});
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_tag", wb_tag, w.tag);
                    chk("wb_data", wb_data, w.data);
                end
            end
            wb_stall   = wb_valid && !wb_ready;
            stall_tag  = wb_tag;
            stall_data = wb_data;
        end else begin
            wb_stall = 1'b0;
        end
    end

    // One clock of stimulus; the model applies the same request by the buffer's rules.
    task automatic step(input bit lv, input logic [TW-1:0] lt, input bit iv, input logic [TW-1:0] it,
                        input logic [DW-1:0] id, input bit idt, input bit wr);
        bit rdy, hit, fifo;
        int hi, slot;
        @(posedge clk); #1;
        lkp_valid = lv; lkp_tag = lt; ins_valid = iv; ins_tag = it;
        ins_data = id; ins_dirty = idt; wb_ready = wr; flush_req = 1'b0;
        #1;
        rdy = !(m_pend && !wr);
        chk("ins_ready", ins_ready, rdy);
        hit = 1'b0; hi = -1;
        if (lv) begin
            for (int i = 0; i < NE; i++)
                if (hi < 0 && m_valid[i] && m_tag[i] == lt) begin hit = 1'b1; hi = i; end
            if (hit) begin m_last_data = m_data[hi]; m_last_dirty = m_dirty[hi]; end
            rsp_q.push_back('{cyc + 1, hit, m_last_data, m_last_dirty});
        end
        if (m_pend && wr) m_pend = 1'b0;
        if (iv && rdy) begin
            slot = -1; fifo = 1'b0;
            for (int i = 0; i < NE; i++) if (slot < 0 && m_valid[i] && m_tag[i] == it) slot = i;
            for (int i = 0; i < NE; i++) if (slot < 0 && !m_valid[i]) slot = i;
            if (slot < 0) begin slot = m_ptr; fifo = 1'b1; m_ptr = (m_ptr + 1) % NE; end
            if (fifo && m_dirty[slot] && !(hit && hi == slot)) begin
                wb_q.push_back('{m_tag[slot], m_data[slot]});
                m_pend = 1'b1;
            end
            if (hit) m_valid[hi] = 1'b0;
            m_valid[slot] = 1'b1; m_tag[slot] = it; m_data[slot] = id; m_dirty[slot] = idt;
        end else if (hit) begin
            m_valid[hi] = 1'b0;
        end
    endtask

    // Flush: every dirty line leaves in index order, then everything is invalid.
    task automatic do_flush();
        bit seen;
        @(posedge clk); #1;
        lkp_valid = 1'b0; ins_valid = 1'b0; wb_ready = 1'b1; flush_req = 1'b1;
        m_pend = 1'b0;
        for (int i = 0; i < NE; i++) if (m_valid[i] && m_dirty[i]) wb_q.push_back('{m_tag[i], m_data[i]});
        for (int i = 0; i < NE; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        m_ptr = 0;
        @(posedge clk); #1;
        flush_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            lkp_valid = 1'b0;
            if (flush_done) begin
                seen = 1'b1;
            end else begin
                chk("ins_ready_flush", ins_ready, 1'b0);
                if (k == 0 || $urandom_range(0, 1) == 1) begin
                    lkp_valid = 1'b1;
                    lkp_tag   = 32'($urandom_range(0, 15));
                    rsp_q.push_back('{cyc + 1, 1'b0, m_last_data, m_last_dirty});
                end
            end
        end
        chk("flush_done_seen", seen, 1'b1);
        @(posedge clk); #1;
        chk("flush_done_pulse", flush_done, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        lkp_valid = 1'b0; ins_valid = 1'b0; wb_ready = 1'b0; flush_req = 1'b0;
        lkp_tag = '0; ins_tag = '0; ins_data = '0; ins_dirty = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_hit", rsp_hit, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_dirty", rsp_dirty, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_tag", wb_tag, '0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_ins_ready", ins_ready, 1'b0);
        rst = 1'b0;
    endtask

    logic [DW-1:0] a5;
    bit            seen;
    logic [TW-1:0] rt;

    initial begin
        apply_reset();
        // Miss after reset on tag 0.
        step(1'b1, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Hit returns the line and removes it.
        a5 = {4{32'hA5A5_A5A5}};
        step(1'b0, 32'h0, 1'b1, 32'h100, a5, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Dirty displacement with back-pressure, then pointer wrap.
        for (int t = 1; t <= 5; t++) step(1'b0, 32'h0, 1'b1, 32'(t), pat(32'(t)), 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 32'h6, pat(32'h6), 1'b1, 1'b0);
        chk("wb_valid_stalled", wb_valid, 1'b1);
        chk("wb_tag_stalled", wb_tag, 32'h1);
        for (int t = 6; t <= 8; t++) step(1'b0, 32'h0, 1'b1, 32'(t), pat(32'(t)), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Same-cycle hit on the replacement target: no write-back.
        step(1'b1, 32'h5, 1'b1, 32'h9, pat(32'h9), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'hA, pat(32'hA), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Flush with mixed dirty/clean entries.
        do_flush();
        step(1'b0, 32'h0, 1'b1, 32'h20, pat(32'h20), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h21, pat(32'h21), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h22, pat(32'h22), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h23, pat(32'h23), 1'b0, 1'b1);
        do_flush();
        for (int t = 32'h20; t <= 32'h23; t++) step(1'b1, 32'(t), 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Reset while a flush write-back is stalled.
        step(1'b0, 32'h0, 1'b1, 32'h30, pat(32'h30), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h31, pat(32'h31), 1'b1, 1'b1);
        @(posedge clk); #1;
        lkp_valid = 1'b0; ins_valid = 1'b0; wb_ready = 1'b0; flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (wb_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("flush_wb_start", seen, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_ins_ready", ins_ready, 1'b0);
        chk("midrst_flush_done", flush_done, 1'b0);
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 32'h30, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h31, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        // Randomized traffic over a small tag pool, with one flush midway.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_flush();
            rt = 32'h40 + 32'($urandom_range(0, 5));
            step(bit'($urandom_range(0, 1)), rt,
                 bit'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 5)),
                 {$urandom, $urandom, $urandom, $urandom}, bit'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        end
        repeat (4) step(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("rsp_queue_drained", 32'(rsp_q.size()), '0);
        chk("wb_queue_drained", 32'(wb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
